// File: rtl/tli4970_multi_reader_if.sv
// Shared SPI bus for a bank of TLI4970 current sensors.
// One SCK, one MISO and an active-low chip select per sensor.
//   spi_clk  : SCK, driven by the reader, idle low
//   spi_cs   : per-sensor chip select, active low, driven by the reader
//   spi_miso : sensor data back to the reader
// master modport = reader side, slave modport = sensor side.
interface tli4970_multi_reader_if #(
  parameter int NUM_CH = 4
);
  logic              spi_clk;
  logic [NUM_CH-1:0] spi_cs;
  logic              spi_miso;

  modport master (output spi_clk, output spi_cs, input spi_miso);
  modport slave  (input spi_clk, input spi_cs, output spi_miso);
endinterface

// File: rtl/tli4970_multi_reader.sv
// Round-robin readout engine for up to NUM_CH TLI4970 current sensors.
// Each sweep reads one 16-bit frame from every channel in turn, checks
// parity, splits current frames from status frames and publishes an
// offset-corrected signed current with a one-clock valid strobe.
// Ports:
//   clk, reset_n      : clock, synchronous active-low reset
//   enable            : free-running periodic sweeps at UPDATE_FREQ
//   trigger           : one-clock pulse, starts a sweep when idle
//   spi               : shared SPI bus (master modport)
//   current           : 16 bits per channel, signed, channel i at [16i+15:16i]
//   current_valid     : per-channel one-clock update strobe
//   status_word       : last status frame per channel
//   ocd, parity_err   : per-channel overcurrent flag / sticky parity error
//   overrun           : sticky, a periodic/trigger start hit a busy sweep
//   busy              : sweep in progress
module tli4970_multi_reader #(
  parameter int NUM_CH      = 4,
  parameter int CLK_FREQ    = 16_000_000,
  parameter int SCK_DIV     = 16,
  parameter int UPDATE_FREQ = 100,
  parameter int OFFSET      = 4096
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic                   trigger,
  tli4970_multi_reader_if.master spi,
  output logic [16*NUM_CH-1:0]   current,
  output logic [NUM_CH-1:0]      current_valid,
  output logic [16*NUM_CH-1:0]   status_word,
  output logic [NUM_CH-1:0]      ocd,
  output logic [NUM_CH-1:0]      parity_err,
  output logic                   overrun,
  output logic                   busy
);

  localparam int P   = CLK_FREQ / UPDATE_FREQ;
  localparam int TW  = (P > 1) ? $clog2(P) : 1;
  localparam int DW  = $clog2(SCK_DIV);
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [15:0]    OFFSET_W = 16'(OFFSET);
  localparam logic [TW-1:0]  TMR_LAST = TW'(P - 1);
  localparam logic [DW-1:0]  DIV_LAST = DW'(SCK_DIV - 1);
  localparam logic [CHW-1:0] CH_LAST  = CHW'(NUM_CH - 1);

  typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD, DECODE, GAP} state_t;

  state_t                state_reg, state_next;
  logic [TW-1:0]         tmr_reg;
  logic [DW-1:0]         div_reg;
  logic [CHW-1:0]        ch_reg;
  logic [3:0]            bit_cnt_reg;
  logic                  phase_reg;
  logic                  sck_reg;
  logic [15:0]           shreg_reg;
  logic [16*NUM_CH-1:0]  current_reg, status_reg;
  logic [NUM_CH-1:0]     valid_reg, ocd_reg, perr_reg;
  logic                  overrun_reg;
  logic [NUM_CH-1:0]     cs_n;
  logic                  frame_active;

  logic        tmr_wrap, start_req, div_run, tick, decode_now;
  logic [15:0] dec_cur;

  assign tmr_wrap  = (tmr_reg == TMR_LAST);
  assign start_req = (tmr_wrap && enable) || trigger;
  // The divider is frozen in IDLE and during the single-clock DECODE, so
  // the GAP that follows still lasts a full half-period.
  assign div_run   = (state_reg != IDLE) && (state_reg != DECODE);
  assign tick      = div_run && (div_reg == DIV_LAST);
  // shreg is complete at the end of CS_HOLD; latching results on that edge
  // makes the new current and its strobe visible during the DECODE clock.
  assign decode_now = (state_reg == CS_HOLD) && tick;
  assign dec_cur    = {3'b000, shreg_reg[12:0]} - OFFSET_W;

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:     if (start_req) state_next = CS_SETUP;
      CS_SETUP: if (tick) state_next = SHIFT;
      SHIFT:    if (tick && phase_reg && bit_cnt_reg == 4'd0) state_next = CS_HOLD;
      CS_HOLD:  if (tick) state_next = DECODE;
      DECODE:   state_next = GAP;
      GAP:      if (tick) state_next = (ch_reg == CH_LAST) ? IDLE : CS_SETUP;
      default:  state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy         = (state_reg != IDLE);
    frame_active = (state_reg == CS_SETUP) || (state_reg == SHIFT) ||
                   (state_reg == CS_HOLD);
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_cs
    assign cs_n[gi] = !(frame_active && ch_reg == CHW'(gi));
  end

  assign spi.spi_cs     = cs_n;
  assign spi.spi_clk    = sck_reg;
  assign current        = current_reg;
  assign status_word    = status_reg;
  assign current_valid  = valid_reg;
  assign ocd            = ocd_reg;
  assign parity_err     = perr_reg;
  assign overrun        = overrun_reg;

  // Timer, SCK generation, shifting and per-channel result registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tmr_reg     <= '0;
      div_reg     <= '0;
      ch_reg      <= '0;
      bit_cnt_reg <= '0;
      phase_reg   <= 1'b0;
      sck_reg     <= 1'b0;
      shreg_reg   <= '0;
      current_reg <= '0;
      status_reg  <= '0;
      valid_reg   <= '0;
      ocd_reg     <= '0;
      perr_reg    <= '0;
      overrun_reg <= 1'b0;
    end else begin
      tmr_reg <= tmr_wrap ? '0 : tmr_reg + 1'b1;

      if (!div_run || tick) div_reg <= '0;
      else                  div_reg <= div_reg + 1'b1;

      if (start_req && state_reg != IDLE) overrun_reg <= 1'b1;

      if (state_reg == IDLE && start_req)
        ch_reg <= '0;
      else if (state_reg == GAP && tick && ch_reg != CH_LAST)
        ch_reg <= ch_reg + 1'b1;

      if (state_reg == CS_SETUP) begin
        bit_cnt_reg <= 4'd15;
        phase_reg   <= 1'b0;
        sck_reg     <= 1'b0;
      end else if (state_reg == SHIFT && tick) begin
        // first tick of each bit raises SCK, second lowers it and samples
        if (!phase_reg) begin
          sck_reg   <= 1'b1;
          phase_reg <= 1'b1;
        end else begin
          sck_reg     <= 1'b0;
          phase_reg   <= 1'b0;
          shreg_reg   <= {shreg_reg[14:0], spi.spi_miso};
          bit_cnt_reg <= bit_cnt_reg - 4'd1;
        end
      end

      valid_reg <= '0;
      if (decode_now) begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (ch_reg == CHW'(i)) begin
            if (^shreg_reg) begin
              perr_reg[i] <= 1'b1;
            end else if (shreg_reg[15]) begin
              status_reg[16*i +: 16] <= shreg_reg;
            end else begin
              current_reg[16*i +: 16] <= dec_cur;
              ocd_reg[i]              <= shreg_reg[13];
              valid_reg[i]            <= 1'b1;
              perr_reg[i]             <= 1'b0;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_tli4970_multi_reader.sv
module tb_tli4970_multi_reader;
  localparam int NCH   = 2;
  localparam int SDIV  = 2;
  localparam int CLKF  = 10000;
  localparam int UPD   = 100;            // timer period 100 clocks
  localparam int FRAME = 35 * SDIV + 1;
  localparam int SWEEP = NCH * FRAME;    // 142
  localparam int CSLOW = 34 * SDIV;      // 68

  logic clk = 1'b0, reset_n = 1'b0, enable = 1'b0, trigger = 1'b0;
  logic [16*NCH-1:0] current, status_word;
  logic [NCH-1:0]    current_valid, ocd, parity_err;
  logic              overrun, busy;

  tli4970_multi_reader_if #(.NUM_CH(NCH)) spi ();

  tli4970_multi_reader #(
    .NUM_CH(NCH), .CLK_FREQ(CLKF), .SCK_DIV(SDIV), .UPDATE_FREQ(UPD), .OFFSET(4096)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .trigger(trigger), .spi(spi),
    .current(current), .current_valid(current_valid), .status_word(status_word),
    .ocd(ocd), .parity_err(parity_err), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0;

  // Sensor responses for the next sweep, and the reference model state
  logic [15:0] resp [NCH];
  logic [15:0] m_cur [NCH];
  logic [15:0] m_stat [NCH];
  bit          m_ocd [NCH];
  bit          m_perr [NCH];
  int          exp_v [NCH];

  // Measurements of one sweep
  int m_busy, m_overlap;
  int m_csl [NCH];
  int m_vcnt [NCH];

  // Sensor model: presents the next bit after each SCK rising edge
  int sens_bit = 15;
  bit sck_prev = 1'b0;
  always @(negedge clk) begin
    if (&spi.spi_cs) begin
      sens_bit     = 15;
      spi.spi_miso = 1'($urandom);
    end else if (spi.spi_clk && !sck_prev) begin
      for (int i = 0; i < NCH; i++)
        if (!spi.spi_cs[i] && sens_bit >= 0) spi.spi_miso = resp[i][sens_bit];
      sens_bit--;
    end
    sck_prev = spi.spi_clk;
  end

  task automatic model_clear();
    for (int c = 0; c < NCH; c++) begin
      m_cur[c] = '0; m_stat[c] = '0; m_ocd[c] = 0; m_perr[c] = 0; exp_v[c] = 0;
    end
  endtask

  task automatic model_frame(input int c, input logic [15:0] w);
    int v;
    exp_v[c] = 0;
    if (^w) begin
      m_perr[c] = 1;
    end else if (w[15]) begin
      m_stat[c] = w;
    end else begin
      v = int'(w & 16'h1FFF) - 4096;
      m_cur[c]  = v[15:0];
      m_ocd[c]  = w[13];
      m_perr[c] = 0;
      exp_v[c]  = 1;
    end
  endtask

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    w = 16'($urandom);
    if ($urandom_range(0, 3) != 0 && (^w)) w[0] = ~w[0];
    return w;
  endfunction

  // Trigger one sweep, advance the model, and measure bus/strobe activity
  task automatic sweep_trigger();
    @(negedge clk) trigger = 1'b1;
    @(negedge clk) trigger = 1'b0;
    for (int c = 0; c < NCH; c++) model_frame(c, resp[c]);
    m_busy = 0; m_overlap = 0;
    for (int c = 0; c < NCH; c++) begin m_csl[c] = 0; m_vcnt[c] = 0; end
    while (busy === 1'b1 && m_busy < 4 * SWEEP) begin
      m_busy++;
      if ($countones(~spi.spi_cs) > 1) m_overlap++;
      for (int c = 0; c < NCH; c++) begin
        if (spi.spi_cs[c] === 1'b0) m_csl[c]++;
        if (current_valid[c] === 1'b1) m_vcnt[c]++;
      end
      @(negedge clk);
    end
    $display("sweep words %h %h busy_clks=%0d cur=%h stat=%h perr=%b ocd=%b",
             resp[0], resp[1], m_busy, current, status_word, parity_err, ocd);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    model_clear();
    n_total++; if (spi.spi_cs !== '1) $display("FAIL reset_cs got %b exp %b", spi.spi_cs, {NCH{1'b1}}); else n_pass++;
    n_total++; if (spi.spi_clk !== 1'b0) $display("FAIL reset_sck got %b exp 0", spi.spi_clk); else n_pass++;
    n_total++; if (current !== '0 || status_word !== '0) $display("FAIL reset_data got %h/%h exp 0", current, status_word); else n_pass++;
    n_total++; if ({current_valid, ocd, parity_err, overrun, busy} !== '0)
      $display("FAIL reset_flags got %b exp 0", {current_valid, ocd, parity_err, overrun, busy}); else n_pass++;
    reset_n = 1'b1;
    m_busy = 0;
    repeat (20) begin @(negedge clk); if (busy !== 1'b0) m_busy++; end
    n_total++; if (m_busy != 0) $display("FAIL reset_idle busy_clks got %0d exp 0", m_busy); else n_pass++;
  endtask

  task automatic test_basic();
    resp[0] = 16'h1064; resp[1] = 16'h0F9C;
    sweep_trigger();
    n_total++; if (m_busy != SWEEP) $display("FAIL basic_sweep_len got %0d exp %0d", m_busy, SWEEP); else n_pass++;
    n_total++; if (m_overlap != 0) $display("FAIL basic_cs_overlap got %0d exp 0", m_overlap); else n_pass++;
    for (int c = 0; c < NCH; c++) begin
      n_total++; if (m_csl[c] != CSLOW) $display("FAIL basic_cs_low[%0d] got %0d exp %0d", c, m_csl[c], CSLOW); else n_pass++;
    end
    n_total++; if (current[15:0] !== 16'h0064) $display("FAIL basic_cur0 got %h exp 0064", current[15:0]); else n_pass++;
    n_total++; if (current[31:16] !== 16'hFF9C) $display("FAIL basic_cur1 got %h exp ff9c", current[31:16]); else n_pass++;
    for (int c = 0; c < NCH; c++) begin
      n_total++; if (m_vcnt[c] != exp_v[c]) $display("FAIL basic_valid[%0d] got %0d exp %0d", c, m_vcnt[c], exp_v[c]); else n_pass++;
      n_total++; if (ocd[c] !== m_ocd[c]) $display("FAIL basic_ocd[%0d] got %b exp %b", c, ocd[c], m_ocd[c]); else n_pass++;
    end
  endtask

  task automatic test_parity();
    resp[0] = 16'h1065; resp[1] = rand_word();
    sweep_trigger();
    n_total++; if (parity_err[0] !== 1'b1) $display("FAIL parity_set got %b exp 1", parity_err[0]); else n_pass++;
    n_total++; if (current[15:0] !== m_cur[0]) $display("FAIL parity_hold got %h exp %h", current[15:0], m_cur[0]); else n_pass++;
    n_total++; if (m_vcnt[0] != 0) $display("FAIL parity_novalid got %0d exp 0", m_vcnt[0]); else n_pass++;
    resp[0] = 16'h1064;
    sweep_trigger();
    n_total++; if (parity_err[0] !== 1'b0) $display("FAIL parity_clear got %b exp 0", parity_err[0]); else n_pass++;
    n_total++; if (parity_err[1] !== m_perr[1]) $display("FAIL parity_ch1 got %b exp %b", parity_err[1], m_perr[1]); else n_pass++;
  endtask

  task automatic test_status();
    resp[0] = 16'h8001; resp[1] = rand_word();
    sweep_trigger();
    n_total++; if (status_word[15:0] !== 16'h8001) $display("FAIL status_word got %h exp 8001", status_word[15:0]); else n_pass++;
    n_total++; if (current[15:0] !== m_cur[0]) $display("FAIL status_cur_hold got %h exp %h", current[15:0], m_cur[0]); else n_pass++;
    n_total++; if (m_vcnt[0] != 0) $display("FAIL status_novalid got %0d exp 0", m_vcnt[0]); else n_pass++;
    resp[0] = 16'h7064;
    sweep_trigger();
    n_total++; if (current[15:0] !== 16'h0064) $display("FAIL status_ocd_cur got %h exp 0064", current[15:0]); else n_pass++;
    n_total++; if (ocd[0] !== 1'b1) $display("FAIL status_ocd got %b exp 1", ocd[0]); else n_pass++;
    n_total++; if (m_vcnt[0] != 1) $display("FAIL status_ocd_valid got %0d exp 1", m_vcnt[0]); else n_pass++;
  endtask

  task automatic test_random();
    for (int s = 0; s < 10; s++) begin
      for (int c = 0; c < NCH; c++) resp[c] = rand_word();
      sweep_trigger();
      n_total++; if (m_busy != SWEEP) $display("FAIL rand_sweep_len got %0d exp %0d", m_busy, SWEEP); else n_pass++;
      for (int c = 0; c < NCH; c++) begin
        n_total++; if (current[16*c +: 16] !== m_cur[c]) $display("FAIL rand_cur[%0d] got %h exp %h", c, current[16*c +: 16], m_cur[c]); else n_pass++;
        n_total++; if (status_word[16*c +: 16] !== m_stat[c]) $display("FAIL rand_stat[%0d] got %h exp %h", c, status_word[16*c +: 16], m_stat[c]); else n_pass++;
        n_total++; if (ocd[c] !== m_ocd[c]) $display("FAIL rand_ocd[%0d] got %b exp %b", c, ocd[c], m_ocd[c]); else n_pass++;
        n_total++; if (parity_err[c] !== m_perr[c]) $display("FAIL rand_perr[%0d] got %b exp %b", c, parity_err[c], m_perr[c]); else n_pass++;
        n_total++; if (m_vcnt[c] != exp_v[c]) $display("FAIL rand_valid[%0d] got %0d exp %0d", c, m_vcnt[c], exp_v[c]); else n_pass++;
      end
    end
  endtask

  task automatic test_overrun();
    int run_len, segs, overlap, idle_busy, k;
    bit prev_busy;
    n_total++; if (overrun !== 1'b0) $display("FAIL overrun_pre got %b exp 0", overrun); else n_pass++;
    resp[0] = 16'h1064; resp[1] = 16'h0F9C;
    run_len = 0; segs = 0; overlap = 0; prev_busy = 0;
    @(negedge clk) enable = 1'b1;
    for (int t = 0; t < 700; t++) begin
      @(negedge clk);
      if ($countones(~spi.spi_cs) > 1) overlap++;
      if (busy === 1'b1) begin
        run_len++;
      end else if (prev_busy) begin
        segs++;
        n_total++; if (run_len != SWEEP) $display("FAIL overrun_seg_len got %0d exp %0d", run_len, SWEEP); else n_pass++;
        run_len = 0;
      end
      prev_busy = (busy === 1'b1);
    end
    $display("periodic sweeps completed=%0d overrun=%b", segs, overrun);
    n_total++; if (segs < 3) $display("FAIL overrun_segs got %0d exp >=3", segs); else n_pass++;
    n_total++; if (overlap != 0) $display("FAIL overrun_overlap got %0d exp 0", overlap); else n_pass++;
    n_total++; if (overrun !== 1'b1) $display("FAIL overrun_set got %b exp 1", overrun); else n_pass++;
    enable = 1'b0;
    k = 0;
    while (busy === 1'b1 && k < 4 * SWEEP) begin @(negedge clk); k++; end
    n_total++; if (busy !== 1'b0) $display("FAIL overrun_finish busy got %b exp 0", busy); else n_pass++;
    idle_busy = 0;
    repeat (300) begin @(negedge clk); if (busy !== 1'b0) idle_busy++; end
    n_total++; if (idle_busy != 0) $display("FAIL overrun_disabled busy_clks got %0d exp 0", idle_busy); else n_pass++;
    n_total++; if (overrun !== 1'b1) $display("FAIL overrun_sticky got %b exp 1", overrun); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int k, idle_busy;
    resp[0] = 16'h1064; resp[1] = 16'h0F9C;
    @(negedge clk) trigger = 1'b1;
    @(negedge clk) trigger = 1'b0;
    k = 0;
    while (!(sens_bit == 6 && spi.spi_cs[0] === 1'b0) && k < 300) begin @(negedge clk); k++; end
    n_total++; if (k >= 300) $display("FAIL midreset_reach_bit7 waited %0d clks, limit 300", k); else n_pass++;
    reset_n = 1'b0;
    @(negedge clk);
    model_clear();
    $display("reset during shift: cs=%b sck=%b busy=%b", spi.spi_cs, spi.spi_clk, busy);
    n_total++; if (spi.spi_cs !== '1 || spi.spi_clk !== 1'b0) $display("FAIL midreset_bus got cs=%b sck=%b exp cs=11 sck=0", spi.spi_cs, spi.spi_clk); else n_pass++;
    n_total++; if (current !== '0 || status_word !== '0) $display("FAIL midreset_data got %h/%h exp 0", current, status_word); else n_pass++;
    n_total++; if ({current_valid, ocd, parity_err, overrun, busy} !== '0)
      $display("FAIL midreset_flags got %b exp 0", {current_valid, ocd, parity_err, overrun, busy}); else n_pass++;
    @(negedge clk) reset_n = 1'b1;
    idle_busy = 0;
    repeat (60) begin @(negedge clk); if (busy !== 1'b0) idle_busy++; end
    n_total++; if (idle_busy != 0) $display("FAIL midreset_no_restart busy_clks got %0d exp 0", idle_busy); else n_pass++;
    resp[0] = 16'h0F9C; resp[1] = 16'h1064;
    sweep_trigger();
    n_total++; if (m_busy != SWEEP) $display("FAIL midreset_sweep_len got %0d exp %0d", m_busy, SWEEP); else n_pass++;
    for (int c = 0; c < NCH; c++) begin
      n_total++; if (current[16*c +: 16] !== m_cur[c]) $display("FAIL midreset_cur[%0d] got %h exp %h", c, current[16*c +: 16], m_cur[c]); else n_pass++;
    end
  endtask

  initial begin
    spi.spi_miso = 1'b0;
    for (int c = 0; c < NCH; c++) resp[c] = '0;
    test_reset();
    test_basic();
    test_parity();
    test_status();
    test_random();
    test_overrun();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout reached 2000000 time units, limit 2000000");
    $fatal(1, "timeout");
  end

endmodule
